// File: rtl/io_out_buffer.sv
// rtl/io_out_buffer.sv - FWFT output FIFO between the CPU output stage and an external consumer
//
// Buffers words written by the CPU (outFlag/out) in a DEPTH-entry
// first-word-fall-through FIFO and drains them over a ready/valid handshake.
// Writes are only accepted after startIO; a write that finds the FIFO full
// (with no simultaneous pop) is dropped, raises a sticky overflow flag and
// halts the buffer until the next startIO. Reads continue in every state.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   startIO   in   start/restart pulse (IDLE->RUN, HALT->RUN)
//   outFlag   in   CPU write strobe
//   out       in   CPU write data [WIDTH]
//   outValid  out  head word available
//   outData   out  head word [WIDTH], meaningful only with outValid
//   outReady  in   consumer accepts the head word
//   stallIO   out  almost full or not running; CPU must hold its output write
//   count     out  occupancy 0..DEPTH [CNTWIDTH]
//   overflow  out  sticky: a write was dropped
//   running   out  buffer is accepting writes

module io_out_buffer #(
  parameter int WIDTH    = 36,
  parameter int DEPTH    = 8,
  parameter int PTRWIDTH = $clog2(DEPTH),
  parameter int CNTWIDTH = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                startIO,
  input  logic                outFlag,
  input  logic [WIDTH-1:0]    out,
  output logic                outValid,
  output logic [WIDTH-1:0]    outData,
  input  logic                outReady,
  output logic                stallIO,
  output logic [CNTWIDTH-1:0] count,
  output logic                overflow,
  output logic                running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTRWIDTH-1:0] wrPtr;
  logic [PTRWIDTH-1:0] rdPtr;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full     = (count == CNTWIDTH'(DEPTH));
  assign outValid = (count != '0);
  assign outData  = mem[rdPtr];
  assign pop      = outValid && outReady;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign push     = (state == RUN) && outFlag && (!full || pop);
  assign drop     = (state == RUN) && outFlag && full && !pop;

  assign running  = (state == RUN);
  // The CPU sees this a cycle late; stalling at DEPTH-1 leaves room for the
  // write already in flight when the stall is observed.
  assign stallIO  = (count >= CNTWIDTH'(DEPTH - 1)) || (state != RUN);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startIO) stateNext = RUN;
      RUN:     if (drop)    stateNext = HALT;
      HALT:    if (startIO) stateNext = RUN;
      default:              stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if ((state == HALT) && startIO) begin
      overflow <= 1'b0;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTRWIDTH'(1);
      if (pop)  rdPtr <= rdPtr + PTRWIDTH'(1);
      if (push && !pop) begin
        count <= count + CNTWIDTH'(1);
      end else if (pop && !push) begin
        count <= count - CNTWIDTH'(1);
      end
    end
  end

  // Storage is not reset; contents behind an empty FIFO are never presented.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= out;
  end

endmodule
